fold_mm_seq: RTL and testbench
==============================

# fold_mm_seq

Operand sequencer and initiator for the folded 16-row GF(2^n) Montgomery multiplier array.
- Accepts one 128-bit A/B operand pair plus algorithm mode over a valid/ready handshake.
- Splits B into per-row nibble passes and drives the array's `B`/`sel_op` pins for one or two folded passes.
- Captures the array's registered C and returns it on a valid/ready result port.
- Sits between the cipher datapath's operand buffers and the multiplier array.

## Interface
Parameters:
- `N`, 128, operand/result width (16 rows × 8 bits)
- `ROWS`, 16, array rows; array B width is 4·ROWS

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand request valid
- `in_ready`  out  1  sequencer can accept a request
- `in_a`  in  N  multiplicand, byte r feeds array row r
- `in_b`  in  N  multiplier, byte r belongs to row r
- `in_mode`  in  3  algorithm mode (array alg_mode encoding, 0–7)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumer ready
- `out_c`  out  N  product
- `out_err`  out  1  result is an illegal-mode error (see Configuration)
- `mm_a`  out  N  to array A
- `mm_b`  out  4·ROWS  to array B
- `mm_sel_op`  out  1  to array sel_op: 0 = fresh pass, 1 = accumulate on registered C
- `mm_alg_mode`  out  3  to array alg_mode
- `mm_c`  in  N  array registered output C

## Operation
- States: IDLE, P0, P1, CAP, ERR.
- **IDLE**
  - `in_ready = !out_valid || out_ready`.
  - On `in_valid && in_ready`: latch A, B and mode into operand registers.
  - Next state is P0, or ERR for mode 7 when error checking is compiled in.
- **P0**
  - Drives `mm_b[4r+3:4r] = B[8r+3:8r]` for every row r, with `mm_sel_op = 0`.
  - Next state is CAP for modes 5 and 6 (4-bit elements, single pass); otherwise P1.
- **P1**
  - Drives `mm_b[4r+3:4r] = B[8r+7:8r+4]`, with `mm_sel_op = 1`.
  - Next state is CAP.
- **CAP**
  - `mm_c` now holds the final pass result.
  - At the clock edge: `out_c <= mm_c`, `out_err <= 0`, `out_valid <= 1`.
  - Next state is IDLE.
- **ERR**
  - At the clock edge: `out_c <= 0`, `out_err <= 1`, `out_valid <= 1`.
  - Next state is IDLE. The array is not exercised.
- Array outputs outside P0/P1: `mm_b = 0`, `mm_sel_op = 0`.
- `mm_a` and `mm_alg_mode` always reflect the latched operand registers.
- Result register:
  - Holds until `out_valid && out_ready`, then `out_valid` clears.
  - Result load and result drain never coincide, because CAP/ERR are entered only after accept with the output free.
- Single-pass modes use only the low nibble of each B byte; the upper nibble is ignored.

## Timing
- Reset values:
  - `out_valid = 0`, `out_err = 0`, `out_c = 0`, `in_ready = 1`.
  - `mm_b = 0`, `mm_sel_op = 0`, `mm_a = 0`, `mm_alg_mode = 0`, state IDLE.
- Accept at edge 0:
  - Two-pass: P0 in cycle 1, P1 in cycle 2, CAP in cycle 3, `out_valid` high from cycle 4 (latency 4).
  - Single-pass: latency 3.
  - ERR: latency 2.
- Throughput:
  - One two-pass op every 4 cycles when `out_ready` is held high.
  - Same-cycle drain of the old result and accept of the new request in IDLE is permitted.
- Backpressure:
  - With `out_valid = 1` and `out_ready = 0`, `in_ready` stays low.
  - `out_c` and `out_err` stay stable.
- `in_*` are sampled only on the accept edge; changes during P0–CAP have no effect.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and clears `out_valid`; the in-flight op is discarded.
  - Stale array C is harmless because the next P0 uses `sel_op = 0`.

## Configuration
- `FOLD_MM_ERR_EN` defined:
  - Mode 7 (array has no coefficients for it) takes the ERR path.
  - Produces `out_c = 0` and `out_err = 1`.
- Not defined:
  - ERR state is absent and `out_err` is tied 0.
  - Mode 7 runs as a normal two-pass op and returns whatever `mm_c` holds in CAP.

## Test plan
- Mode 0, `in_b = {16{8'hA5}}`, `out_ready = 1`:
  - `mm_b = 64'h5555…5`, `sel_op = 0` in cycle 1.
  - `mm_b = 64'hAAAA…A`, `sel_op = 1` in cycle 2.
  - `out_valid` in cycle 4; `out_c` matches the array reference model.
- Mode 5, `in_b = {16{8'h3C}}`:
  - Exactly one pass with `mm_b = 64'hCCCC…C`; P1 never entered.
  - `out_valid` in cycle 3.
- Backpressure: hold `out_ready = 0` for 10 cycles after a result.
  - `in_ready = 0` throughout; `out_c` stable.
  - Release: drain and new accept in the same cycle.
- Back-to-back mode 2 ops with `out_ready = 1`: accepts every 4 cycles; results in order.
- Mode 7:
  - With `FOLD_MM_ERR_EN`: `out_err = 1`, `out_c = 0` at latency 2, `mm_b` stays 0.
  - Without the macro: a normal two-pass op at latency 4 with `out_err = 0`.
- Assert `rst` during P1: the next cycle shows IDLE with `out_valid = 0` and `mm_sel_op = 0`. A following mode 0 op yields the correct product.

Source files
------------

// File: rtl/fold_mm_seq_if.sv
// Request, result and multiplier-array bus of the folded Montgomery multiplier sequencer.
// The master side is the requester plus array; the slave side is the sequencer.
interface fold_mm_seq_if #(
  parameter int unsigned N    = 128,
  parameter int unsigned ROWS = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_c;
  logic             out_err;
  logic [N-1:0]     mm_a;
  logic [4*ROWS-1:0] mm_b;
  logic             mm_sel_op;
  logic [2:0]       mm_alg_mode;
  logic [N-1:0]     mm_c;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready, mm_c,
    input  in_ready, out_valid, out_c, out_err, mm_a, mm_b, mm_sel_op, mm_alg_mode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready, mm_c,
    output in_ready, out_valid, out_c, out_err, mm_a, mm_b, mm_sel_op, mm_alg_mode
  );
endinterface

// File: rtl/fold_mm_seq.sv
// Operand sequencer for the folded 16-row GF(2^n) Montgomery array: one or two nibble passes.
// Define FOLD_MM_ERR_EN to reject mode 7 with an error result instead of running it.
module fold_mm_seq #(
  parameter int unsigned N    = 128,
  parameter int unsigned ROWS = 16
) (
  input  logic          clk,
  input  logic          rst,
  fold_mm_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StP0,
    StP1,
`ifdef FOLD_MM_ERR_EN
    StErr,
`endif
    StCap
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        a_q, a_d;
  logic [N-1:0]        b_q, b_d;
  logic [2:0]          mode_q, mode_d;
  logic [N-1:0]        c_q, c_d;
  logic                valid_q, valid_d;
  logic                in_ready;
  logic [4*ROWS-1:0]   mm_b;
  logic                mm_sel_op;
  logic                single_pass;
`ifdef FOLD_MM_ERR_EN
  logic                err_q, err_d;
`endif

  // Modes 5 and 6 use 4-bit elements, so the low nibble of each B byte is the whole operand.
  assign single_pass = (mode_q == 3'd5) || (mode_q == 3'd6);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    c_d       = c_q;
    valid_d   = valid_q;
`ifdef FOLD_MM_ERR_EN
    err_d     = err_q;
`endif
    in_ready  = 1'b0;
    mm_b      = '0;
    mm_sel_op = 1'b0;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        in_ready = !valid_q || bus.out_ready;
        if (bus.in_valid && in_ready) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          mode_d  = bus.in_mode;
          state_d = StP0;
`ifdef FOLD_MM_ERR_EN
          if (bus.in_mode == 3'd7) begin
            state_d = StErr;
          end
`endif
        end
      end
      StP0: begin
        for (int r = 0; r < int'(ROWS); r++) begin
          mm_b[4*r +: 4] = b_q[8*r +: 4];
        end
        state_d = single_pass ? StCap : StP1;
      end
      StP1: begin
        for (int r = 0; r < int'(ROWS); r++) begin
          mm_b[4*r +: 4] = b_q[8*r+4 +: 4];
        end
        mm_sel_op = 1'b1;
        state_d   = StCap;
      end
      StCap: begin
        c_d     = bus.mm_c;
        valid_d = 1'b1;
`ifdef FOLD_MM_ERR_EN
        err_d   = 1'b0;
`endif
        state_d = StIdle;
      end
`ifdef FOLD_MM_ERR_EN
      StErr: begin
        c_d     = '0;
        err_d   = 1'b1;
        valid_d = 1'b1;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

`ifdef FOLD_MM_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_c       = c_q;
  assign bus.mm_a        = a_q;
  assign bus.mm_b        = mm_b;
  assign bus.mm_sel_op   = mm_sel_op;
  assign bus.mm_alg_mode = mode_q;

endmodule

// File: tb/tb_fold_mm_seq.sv
// Self-checking bench for fold_mm_seq; a simple stand-in array register supplies mm_c.
module tb_fold_mm_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fold_mm_seq_if #(.N(128), .ROWS(16)) bus ();

  fold_mm_seq #(.N(128), .ROWS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in array: fresh pass mixes A, doubled B and mode; accumulate rotates C first.
  logic [127:0] arr_c;
  always @(posedge clk) begin
    if (!bus.mm_sel_op) begin
      arr_c <= bus.mm_a ^ {bus.mm_b, bus.mm_b} ^ {125'd0, bus.mm_alg_mode};
    end else begin
      arr_c <= {arr_c[126:0], arr_c[127]} ^ bus.mm_a ^ {bus.mm_b, bus.mm_b};
    end
  end
  assign bus.mm_c = arr_c;

  function automatic logic [63:0] nib(input logic [127:0] b, input bit hi);
    logic [63:0] n;
    for (int r = 0; r < 16; r++) begin
      n[4*r +: 4] = hi ? b[8*r+4 +: 4] : b[8*r +: 4];
    end
    return n;
  endfunction

  function automatic logic [127:0] model_c(input logic [127:0] a, input logic [127:0] b,
                                           input logic [2:0] mode);
    logic [63:0]  lo;
    logic [63:0]  hi;
    logic [127:0] c;
    lo = nib(b, 1'b0);
    hi = nib(b, 1'b1);
    c  = a ^ {lo, lo} ^ {125'd0, mode};
    if (!(mode == 3'd5 || mode == 3'd6)) begin
      c = {c[126:0], c[127]} ^ a ^ {hi, hi};
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] mode, input logic [127:0] a, input logic [127:0] b);
    bus.in_mode = mode;
    bus.in_a    = a;
    bus.in_b    = b;
  endtask

  // Accept one op, scramble the inputs, then count cycles until out_valid.
  task automatic run_op(input logic [2:0] mode, input logic [127:0] a, input logic [127:0] b,
                        output int lat, output logic [127:0] c, output logic err);
    int w;
    @(negedge clk);
    drive(mode, a, b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drive(mode ^ 3'd1, ~a, ~b);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    c   = bus.out_c;
    err = bus.out_err;
  endtask

  typedef struct {
    logic [2:0]   mode;
    logic [127:0] a;
    logic [127:0] b;
    int           lat;
    logic [127:0] c;
    logic         err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int           lat;
    logic [127:0] c;
    logic         err;
    logic [127:0] ha, hb, hc;
    logic [127:0] ea[3], eb[3], ec[3];
    int           acc[3];
    int           ai, ri;
    bit           take;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'd0, '0, '0);

    for (int i = 0; i < 8; i++) begin
      vecs[i].mode = 3'(i);
      vecs[i].a    = {4{32'h1357_9BDF}} ^ {16{8'(i * 37 + 1)}};
      vecs[i].b    = {4{32'hF0E1_D2C3}} ^ {16{8'(i * 91 + 5)}};
      vecs[i].lat  = (i == 5 || i == 6) ? 3 : 4;
      vecs[i].c    = model_c(vecs[i].a, vecs[i].b, 3'(i));
      vecs[i].err  = 1'b0;
`ifdef FOLD_MM_ERR_EN
      if (i == 7) begin
        vecs[i].lat = 2;
        vecs[i].c   = '0;
        vecs[i].err = 1'b1;
      end
`endif
    end

    // Reset values.
    #12;
    chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_out_err", {127'd0, bus.out_err}, 128'd0);
    chk("rst_out_c", bus.out_c, 128'd0);
    chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("rst_mm_b", {64'd0, bus.mm_b}, 128'd0);
    chk("rst_sel_op", {127'd0, bus.mm_sel_op}, 128'd0);
    chk("rst_mm_a", bus.mm_a, 128'd0);
    chk("rst_alg_mode", {125'd0, bus.mm_alg_mode}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0 with per-cycle array pin checks.
    ha = {8{16'h4C2B}};
    hb = {16{8'hA5}};
    @(negedge clk);
    drive(3'd0, ha, hb);
    bus.in_valid = 1'b1;
    chk("m0_in_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("m0_p0_mm_b", {64'd0, bus.mm_b}, {64'd0, {16{4'h5}}});
    chk("m0_p0_sel", {127'd0, bus.mm_sel_op}, 128'd0);
    chk("m0_mm_a", bus.mm_a, ha);
    @(negedge clk);
    chk("m0_p1_mm_b", {64'd0, bus.mm_b}, {64'd0, {16{4'hA}}});
    chk("m0_p1_sel", {127'd0, bus.mm_sel_op}, 128'd1);
    @(negedge clk);
    chk("m0_cap_mm_b", {64'd0, bus.mm_b}, 128'd0);
    chk("m0_cap_valid", {127'd0, bus.out_valid}, 128'd0);
    @(negedge clk);
    chk("m0_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("m0_c", bus.out_c, model_c(ha, hb, 3'd0));

    // Mode 5: one pass, upper nibbles ignored.
    hb = {16{8'h3C}};
    @(negedge clk);
    drive(3'd5, ha, hb);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("m5_p0_mm_b", {64'd0, bus.mm_b}, {64'd0, {16{4'hC}}});
    chk("m5_p0_sel", {127'd0, bus.mm_sel_op}, 128'd0);
    @(negedge clk);
    chk("m5_cap_mm_b", {64'd0, bus.mm_b}, 128'd0);
    chk("m5_cap_sel", {127'd0, bus.mm_sel_op}, 128'd0);
    @(negedge clk);
    chk("m5_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("m5_c", bus.out_c, model_c(ha, hb, 3'd5));

`ifdef FOLD_MM_ERR_EN
    // Mode 7 must not exercise the array.
    @(negedge clk);
    drive(3'd7, ha, {16{8'hFF}});
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("m7_err_mm_b", {64'd0, bus.mm_b}, 128'd0);
    @(negedge clk);
    chk("m7_err_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("m7_err_flag", {127'd0, bus.out_err}, 128'd1);
`endif

    // Table of every mode.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, lat, c, err);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].lat));
      chk($sformatf("vec%0d_c", i), c, vecs[i].c);
      chk($sformatf("vec%0d_err", i), {127'd0, err}, {127'd0, vecs[i].err});
    end

    // Backpressure: result held, next request waits, then drain and accept coincide.
    @(negedge clk);
    bus.out_ready = 1'b0;
    ha = {4{32'h0BAD_F00D}};
    hb = {4{32'h6789_ABCD}};
    drive(3'd1, ha, hb);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(3'd2, ~ha, {16{8'h96}});
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("bp_valid", {127'd0, bus.out_valid}, 128'd1);
    hc = model_c(ha, hb, 3'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", k), {127'd0, bus.in_ready}, 128'd0);
      chk($sformatf("bp_c%0d", k), bus.out_c, hc);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", {127'd0, bus.out_valid}, 128'd0);
    chk("bp_new_p0", {64'd0, bus.mm_b}, {64'd0, {16{4'h6}}});
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("bp_new_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("bp_new_c", bus.out_c, model_c(~ha, {16{8'h96}}, 3'd2));

    // Back-to-back mode 2 ops.
    for (int k = 0; k < 3; k++) begin
      ea[k]  = {4{32'h2468_ACE0}} ^ {16{8'(k * 53 + 7)}};
      eb[k]  = {4{32'h1122_3344}} ^ {16{8'(k * 29 + 3)}};
      ec[k]  = model_c(ea[k], eb[k], 3'd2);
      acc[k] = 0;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(3'd2, ea[0], eb[0]);
    bus.in_valid = 1'b1;
    ai = 0;
    ri = 0;
    for (int cyc = 0; cyc < 40 && ri < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.out_valid) begin
        chk($sformatf("b2b_c%0d", ri), bus.out_c, ec[ri]);
        ri++;
      end
      take = bus.in_valid && bus.in_ready;
      if (take) acc[ai] = cyc;
      @(posedge clk);
      #1;
      if (take) begin
        ai++;
        if (ai < 3) drive(3'd2, ea[ai], eb[ai]);
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_count", 128'(ri), 128'd3);
    chk("b2b_gap01", 128'(acc[1] - acc[0]), 128'd4);
    chk("b2b_gap12", 128'(acc[2] - acc[1]), 128'd4);

    // Reset during P1 discards the op.
    @(negedge clk);
    drive(3'd0, {8{16'h5A5A}}, {16{8'h71}});
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_in_p1", {127'd0, bus.mm_sel_op}, 128'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_sel", {127'd0, bus.mm_sel_op}, 128'd0);
    chk("rst_mid_valid", {127'd0, bus.out_valid}, 128'd0);
    @(negedge clk);
    chk("rst_mid_idle", {127'd0, bus.in_ready}, 128'd1);
    chk("rst_mid_valid2", {127'd0, bus.out_valid}, 128'd0);
    rst = 1'b0;
    ha = {4{32'hCAFE_0123}};
    hb = {4{32'h89AB_4567}};
    run_op(3'd0, ha, hb, lat, c, err);
    chk("post_rst_lat", 128'(lat), 128'd4);
    chk("post_rst_c", c, model_c(ha, hb, 3'd0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
